ctrlu_multi: RTL and testbench
==============================

Name: ctrlu_multi

Overview:
Multi-core successor to the single-core HPS run-control unit. It holds one start/stop state machine per soft core, driven by a per-core HPS command line using the same assert-then-release handshake. It adds an optional per-run cycle budget (auto-stop on timeout), sticky stop-cause flags and per-core run-cycle counters readable through a select mux. It sits between the HPS bridge registers and the core array.

Parameters:
NUM_CORES, 4, number of independently controlled cores (>=1)
CNT_WIDTH, 32, width of budget and run-cycle counters
SEL_W, 2, width of cycle_sel; must be >= max(1, clog2(NUM_CORES))

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
hps_cmd  in  NUM_CORES  per-core command line; 1 then back to 0 commits a start or stop
hps_budget  in  CNT_WIDTH  run budget in cycles, shared by all cores, sampled at start commit; 0 = unlimited
cpu_halt  in  NUM_CORES  per-core halt request from the core
cycle_sel  in  SEL_W  selects the core whose run counter drives cycle_cnt
state  out  2*NUM_CORES  core i state at bits [2i+1:2i]
alive  out  NUM_CORES  core i is running
halt_clr  out  NUM_CORES  one-cycle pulse clearing core i halt latch at run start
timeout  out  NUM_CORES  sticky; last run ended by budget exhaustion
halt_seen  out  NUM_CORES  sticky; last run ended by cpu_halt
cycle_cnt  out  CNT_WIDTH  run-cycle counter of the selected core (combinational mux)

Behaviour:
- Reset (asynchronous, any time, including mid-run): every core goes to STOPPED. alive, halt_clr, timeout and halt_seen are 0. The remaining-budget and run counters are 0.
- State encoding per core: STOPPED=00, STARTING=01, STOPPING=10, STARTED=11. All cores are fully independent.
- STOPPED: hps_cmd[i]=1 -> STARTING. cpu_halt is ignored.
- STARTING: waits while hps_cmd[i]=1. On hps_cmd[i]=0:
  - next state STARTED;
  - alive<=1 and halt_clr<=1;
  - rem<=hps_budget and run<=0;
  - timeout<=0 and halt_seen<=0.
- STARTED:
  - halt_clr<=0 every cycle, so the pulse is exactly 1 cycle wide, coincident with the first alive cycle.
  - run increments on every edge while in STARTED, including the leaving edge. It saturates at all-ones. It therefore equals the number of cycles alive was high.
  - Priority 1: hps_cmd[i]=1 -> STOPPING, alive<=0. Flags unchanged.
  - Priority 2: cpu_halt[i]=1 -> STOPPED, alive<=0, halt_seen<=1.
  - Priority 3: budget active (latched budget != 0) and rem==1 -> STOPPED, alive<=0, timeout<=1.
  - Otherwise, if the budget is active, rem decrements.
  - Result: with budget B>0 and no other event, alive is high for exactly B cycles.
- STOPPING: hps_cmd[i]=0 -> STOPPED. cpu_halt is ignored.
- Simultaneous events: hps_cmd beats cpu_halt, and cpu_halt beats timeout. Only one flag is set per run end.
- run and the flags hold their values after stop until the next start commit.
- cycle_cnt = run of core cycle_sel. If cycle_sel >= NUM_CORES, cycle_cnt is 0.
- A start committed while other cores run has no effect on those cores. hps_budget is sampled only at each core's own commit edge.

Test Plan:
- Reset, then pulse hps_cmd[0] (1 for 3 cycles, then 0) with hps_budget=0 -> state[1:0] goes 01 then 11; alive[0]=1; halt_clr[0] is high for exactly 1 cycle; other cores stay 00.
- Core 1 started with hps_budget=5, no halt -> alive[1] high for exactly 5 cycles; state returns to 00; timeout[1]=1; cycle_cnt=5 with cycle_sel=1.
- Core 2 running unlimited, assert cpu_halt[2] after 10 alive cycles -> STOPPED the next edge; halt_seen[2]=1; cycle_cnt (sel=2)=10.
- Core 0 running, hps_cmd[0] and cpu_halt[0] rise in the same cycle -> STOPPING (10); halt_seen[0]=0; after hps_cmd release -> 00.
- Budget=1 and cpu_halt asserted on the first STARTED cycle -> halt_seen=1, timeout=0, run=1. Restarting clears halt_seen and run.
- Assert rst mid-run on all cores -> all state=00; alive, flags and counters 0 immediately, without waiting for a clock edge; cycle_sel=NUM_CORES -> cycle_cnt=0.

Source files
------------

// File: rtl/ctrlu_multi.sv
// Multi-core HPS run-control unit: one start/stop FSM per core with optional
// cycle budget, sticky stop-cause flags and per-core run-cycle counters.
module ctrlu_multi #(
  parameter int NUM_CORES = 4,
  parameter int CNT_WIDTH = 32,
  parameter int SEL_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CORES-1:0]   hps_cmd,
  input  logic [CNT_WIDTH-1:0]   hps_budget,
  input  logic [NUM_CORES-1:0]   cpu_halt,
  input  logic [SEL_W-1:0]       cycle_sel,
  output logic [2*NUM_CORES-1:0] state,
  output logic [NUM_CORES-1:0]   alive,
  output logic [NUM_CORES-1:0]   halt_clr,
  output logic [NUM_CORES-1:0]   timeout,
  output logic [NUM_CORES-1:0]   halt_seen,
  output logic [CNT_WIDTH-1:0]   cycle_cnt
);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'b00,
    ST_STARTING = 2'b01,
    ST_STOPPING = 2'b10,
    ST_STARTED  = 2'b11
  } state_e;

  state_e               state_q     [NUM_CORES];
  state_e               state_d     [NUM_CORES];
  logic [CNT_WIDTH-1:0] rem_q       [NUM_CORES];
  logic [CNT_WIDTH-1:0] rem_d       [NUM_CORES];
  logic [CNT_WIDTH-1:0] run_q       [NUM_CORES];
  logic [CNT_WIDTH-1:0] run_d       [NUM_CORES];
  logic [NUM_CORES-1:0] alive_q,     alive_d;
  logic [NUM_CORES-1:0] halt_clr_q,  halt_clr_d;
  logic [NUM_CORES-1:0] timeout_q,   timeout_d;
  logic [NUM_CORES-1:0] halt_seen_q, halt_seen_d;
  logic [NUM_CORES-1:0] bud_en_q,    bud_en_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) return v;
    return v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    alive_d     = alive_q;
    halt_clr_d  = halt_clr_q;
    timeout_d   = timeout_q;
    halt_seen_d = halt_seen_q;
    bud_en_d    = bud_en_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      run_d[i]   = run_q[i];
      case (state_q[i])
        ST_STOPPED: begin
          if (hps_cmd[i]) state_d[i] = ST_STARTING;
        end
        ST_STARTING: begin
          // Commit on release: budget is latched here and only here.
          if (!hps_cmd[i]) begin
            state_d[i]     = ST_STARTED;
            alive_d[i]     = 1'b1;
            halt_clr_d[i]  = 1'b1;
            rem_d[i]       = hps_budget;
            bud_en_d[i]    = (hps_budget != '0);
            run_d[i]       = '0;
            timeout_d[i]   = 1'b0;
            halt_seen_d[i] = 1'b0;
          end
        end
        ST_STARTED: begin
          halt_clr_d[i] = 1'b0;
          run_d[i]      = sat_inc(run_q[i]);
          if (hps_cmd[i]) begin
            state_d[i] = ST_STOPPING;
            alive_d[i] = 1'b0;
          end else if (cpu_halt[i]) begin
            state_d[i]     = ST_STOPPED;
            alive_d[i]     = 1'b0;
            halt_seen_d[i] = 1'b1;
          end else if (bud_en_q[i] && rem_q[i] == CNT_WIDTH'(1)) begin
            state_d[i]   = ST_STOPPED;
            alive_d[i]   = 1'b0;
            timeout_d[i] = 1'b1;
          end else if (bud_en_q[i]) begin
            rem_d[i] = rem_q[i] - CNT_WIDTH'(1);
          end
        end
        ST_STOPPING: begin
          if (!hps_cmd[i]) state_d[i] = ST_STOPPED;
        end
        default: state_d[i] = ST_STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q     <= '0;
      halt_clr_q  <= '0;
      timeout_q   <= '0;
      halt_seen_q <= '0;
      bud_en_q    <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        state_q[i] <= ST_STOPPED;
        rem_q[i]   <= '0;
        run_q[i]   <= '0;
      end
    end else begin
      alive_q     <= alive_d;
      halt_clr_q  <= halt_clr_d;
      timeout_q   <= timeout_d;
      halt_seen_q <= halt_seen_d;
      bud_en_q    <= bud_en_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
        run_q[i]   <= run_d[i];
      end
    end
  end

  always_comb begin
    state     = '0;
    cycle_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      state[2*i +: 2] = state_q[i];
      if (cycle_sel == SEL_W'(i)) cycle_cnt = run_q[i];
    end
  end

  assign alive     = alive_q;
  assign halt_clr  = halt_clr_q;
  assign timeout   = timeout_q;
  assign halt_seen = halt_seen_q;

endmodule

// File: tb/tb_ctrlu_multi.sv
// Directed bench for ctrlu_multi: start/stop handshake, budget timeout,
// halt/stop priority, sticky flags, counter mux and asynchronous reset.
module tb_ctrlu_multi;
  localparam int NC = 4;
  localparam int CW = 32;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] hps_cmd;
  logic [CW-1:0] hps_budget;
  logic [NC-1:0] cpu_halt;
  logic [SW-1:0] cycle_sel;
  logic [2*NC-1:0] state;
  logic [NC-1:0] alive, halt_clr, timeout, halt_seen;
  logic [CW-1:0] cycle_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  ctrlu_multi #(.NUM_CORES(NC), .CNT_WIDTH(CW), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .hps_cmd(hps_cmd), .hps_budget(hps_budget),
    .cpu_halt(cpu_halt), .cycle_sel(cycle_sel), .state(state), .alive(alive),
    .halt_clr(halt_clr), .timeout(timeout), .halt_seen(halt_seen),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; hps_cmd = '0; hps_budget = '0; cpu_halt = '0; cycle_sel = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_alive", 32'(alive), 32'h0);
    chk("rst_flags", 32'({timeout, halt_seen, halt_clr}), 32'h0);
    chk("rst_cnt", cycle_cnt, 32'h0);

    // Core 0: unlimited start, cmd held 3 cycles
    hps_cmd = 4'b0001;
    tick();
    chk("c0_starting", 32'(state[1:0]), 32'h1);
    chk("c0_alive_early", 32'(alive[0]), 32'h0);
    tick(); tick();
    hps_cmd = 4'b0000;
    tick();
    chk("c0_started", 32'(state[1:0]), 32'h3);
    chk("c0_alive", 32'(alive[0]), 32'h1);
    chk("c0_hclr_on", 32'(halt_clr), 32'h1);
    chk("c0_others", 32'(state[7:2]), 32'h0);
    tick();
    chk("c0_hclr_off", 32'(halt_clr), 32'h0);
    chk("c0_still_alive", 32'(alive[0]), 32'h1);

    // Core 1: budget 5; budget input changed after commit must not matter
    hps_cmd = 4'b0010; hps_budget = 32'd5;
    tick();
    hps_cmd = 4'b0000;
    tick();
    hps_budget = 32'd0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (alive[1]) cnt++;
      tick();
    end
    chk("c1_alive_cycles", 32'(cnt), 32'd5);
    chk("c1_state", 32'(state[3:2]), 32'h0);
    chk("c1_timeout", 32'(timeout[1]), 32'h1);
    chk("c1_halt_seen", 32'(halt_seen[1]), 32'h0);
    cycle_sel = 3'd1;
    #1 chk("c1_cnt", cycle_cnt, 32'd5);
    chk("c0_indep", 32'(alive[0]), 32'h1);

    // Core 2: halt after 10 alive cycles
    hps_cmd = 4'b0100;
    tick();
    hps_cmd = 4'b0000;
    tick();
    for (int k = 0; k < 9; k++) tick();
    chk("c2_alive_10", 32'(alive[2]), 32'h1);
    cpu_halt = 4'b0100;
    tick();
    cpu_halt = 4'b0000;
    chk("c2_state", 32'(state[5:4]), 32'h0);
    chk("c2_alive", 32'(alive[2]), 32'h0);
    chk("c2_halt_seen", 32'(halt_seen[2]), 32'h1);
    chk("c2_timeout", 32'(timeout[2]), 32'h0);
    cycle_sel = 3'd2;
    #1 chk("c2_cnt", cycle_cnt, 32'd10);

    // Core 0: stop command and halt in the same cycle
    hps_cmd = 4'b0001; cpu_halt = 4'b0001;
    tick();
    chk("c0_stopping", 32'(state[1:0]), 32'h2);
    chk("c0_alive_off", 32'(alive[0]), 32'h0);
    chk("c0_no_halt_flag", 32'(halt_seen[0]), 32'h0);
    hps_cmd = 4'b0000; cpu_halt = 4'b0000;
    tick();
    chk("c0_stopped", 32'(state[1:0]), 32'h0);
    chk("c0_flags", 32'({timeout[0], halt_seen[0]}), 32'h0);

    // Core 3: budget 1, halt on the first alive cycle
    hps_cmd = 4'b1000; hps_budget = 32'd1;
    tick();
    hps_cmd = 4'b0000;
    tick();
    hps_budget = 32'd0;
    chk("c3_alive", 32'(alive[3]), 32'h1);
    cpu_halt = 4'b1000;
    tick();
    cpu_halt = 4'b0000;
    chk("c3_state", 32'(state[7:6]), 32'h0);
    chk("c3_halt_seen", 32'(halt_seen[3]), 32'h1);
    chk("c3_timeout", 32'(timeout[3]), 32'h0);
    cycle_sel = 3'd3;
    #1 chk("c3_run", cycle_cnt, 32'd1);
    hps_cmd = 4'b1000;
    tick();
    chk("c3_flag_held", 32'(halt_seen[3]), 32'h1);
    chk("c3_run_held", cycle_cnt, 32'd1);
    hps_cmd = 4'b0000;
    tick();
    chk("c3_restart_flag", 32'(halt_seen[3]), 32'h0);
    chk("c3_restart_run", cycle_cnt, 32'd0);
    chk("c3_restart_hclr", 32'(halt_clr), 32'h8);

    // Restart core 0 alongside running core 3, then reset asynchronously
    hps_cmd = 4'b0001;
    tick();
    hps_cmd = 4'b0000;
    tick();
    chk("mr_alive", 32'(alive), 32'h9);
    chk("mr_timeout", 32'(timeout), 32'h2);
    chk("mr_halt_seen", 32'(halt_seen), 32'h4);
    chk("mr_c3_run", cycle_cnt, 32'd2);
    cycle_sel = 3'd4;
    #1 chk("sel_oob", cycle_cnt, 32'd0);
    cycle_sel = 3'd3;
    #1 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'h0);
    chk("arst_alive", 32'(alive), 32'h0);
    chk("arst_flags", 32'({timeout, halt_seen, halt_clr}), 32'h0);
    chk("arst_cnt", cycle_cnt, 32'd0);
    cycle_sel = 3'd4;
    #1 chk("arst_sel_oob", cycle_cnt, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_state", 32'(state), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
